// File: rtl/mat_spmv_cmac_pkg.sv
// Shared sizing helpers for the complex sparse-matrix x dense-vector MAC engine.
// Latency: none (compile-time constants and functions only).
// Backpressure: none (no logic).
package mat_spmv_cmac_pkg;

    // Width of one complex lane product component: two DW x DW products are summed,
    // which needs one extra bit over 2*DW.
    function automatic int cmul_w(input int dw);
        return 2 * dw + 1;
    endfunction

    // Column-index width for a vector of 'rank' elements; a rank of 1 still gets one bit.
    function automatic int idx_w(input int rank);
        return (rank <= 1) ? 1 : $clog2(rank);
    endfunction

endpackage

// File: rtl/mat_spmv_cmac_cmul.sv
// One lane of the complex multiply: p = v * x, with the product zeroed for a disabled lane.
// Latency: 1 cycle (registered output).
// Backpressure: output holds while en is low.
module mat_spmv_cmac_cmul
    import mat_spmv_cmac_pkg::*;
#(
    parameter int DW = 16,
    localparam int PW = cmul_w(DW)
)
(
    input  logic                 clk,
    input  logic                 en,
    input  logic                 lane_en,
    input  logic signed [DW-1:0] v_re,
    input  logic signed [DW-1:0] v_im,
    input  logic signed [DW-1:0] x_re,
    input  logic signed [DW-1:0] x_im,
    output logic signed [PW-1:0] p_re,
    output logic signed [PW-1:0] p_im
);

    logic signed [PW-1:0] vr_e, vi_e, xr_e, xi_e;
    logic signed [PW-1:0] re_c, im_c;

    // Sign-extend operands first so every product and sum is evaluated at full product width.
    always_comb begin
        vr_e = PW'(v_re);
        vi_e = PW'(v_im);
        xr_e = PW'(x_re);
        xi_e = PW'(x_im);
        re_c = vr_e * xr_e - vi_e * xi_e;
        im_c = vr_e * xi_e + vi_e * xr_e;
    end

    // Register the product; a disabled lane contributes exactly zero to the row sum.
    always_ff @(posedge clk) begin
        if (en) begin
            p_re <= lane_en ? re_c : '0;
            p_im <= lane_en ? im_c : '0;
        end
    end

endmodule

// File: rtl/mat_spmv_cmac.sv
// Complex CSR sparse-matrix x dense-vector MAC: LANES non-zeros per beat, one complex result per row.
// Latency: result valid 3 cycles after the cycle in which the row's last beat is accepted; 1 beat/cycle.
// Backpressure: m_vld & !m_rdy freezes the whole pipeline and drops s_rdy; a vector write also drops s_rdy.
module mat_spmv_cmac
    import mat_spmv_cmac_pkg::*;
#(
    parameter int MAT_RANK = 256,
    parameter int LANES    = 4,
    parameter int DW       = 16,
    parameter int ACC_W    = 40,
    localparam int IDX_W   = idx_w(MAT_RANK)
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vec_wr_en,
    input  logic [IDX_W-1:0]         vec_wr_addr,
    input  logic [DW-1:0]            vec_wr_re,
    input  logic [DW-1:0]            vec_wr_im,
    input  logic [LANES*IDX_W-1:0]   s_col_index,
    input  logic [LANES*DW-1:0]      s_val_re,
    input  logic [LANES*DW-1:0]      s_val_im,
    input  logic [LANES-1:0]         s_lane_en,
    input  logic                     s_last,
    input  logic                     s_vld,
    output logic                     s_rdy,
    output logic [ACC_W-1:0]         m_re,
    output logic [ACC_W-1:0]         m_im,
    output logic [IDX_W-1:0]         m_row,
    output logic                     m_vld,
    input  logic                     m_rdy
);

    localparam int PW = cmul_w(DW);

    logic [DW-1:0] vec_re [MAT_RANK];
    logic [DW-1:0] vec_im [MAT_RANK];

    logic en;
    logic accept;

    logic             s1_vld, s1_last;
    logic [LANES-1:0] s1_lane_en;
    logic             s2_vld, s2_last;

    logic signed [PW-1:0] s2_pr [LANES];
    logic signed [PW-1:0] s2_pi [LANES];

    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] nxt_re, nxt_im;
    logic                    first;
    logic [IDX_W-1:0]        row_cnt;

    assign en     = !m_vld || m_rdy;
    assign s_rdy  = en && !vec_wr_en && rst_n;
    assign accept = s_vld && s_rdy;

    // Dense vector storage; not reset, and written regardless of pipeline stalls.
    always_ff @(posedge clk) begin
        if (vec_wr_en) begin
            vec_re[vec_wr_addr] <= vec_wr_re;
            vec_im[vec_wr_addr] <= vec_wr_im;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0]     col;
        logic signed [DW-1:0] vr, vi, xr, xi;

        assign col = s_col_index[k*IDX_W +: IDX_W];

        // S0 -> S1: capture the lane value and the vector element it indexes (duplicates read independently).
        always_ff @(posedge clk) begin
            if (en) begin
                vr <= s_val_re[k*DW +: DW];
                vi <= s_val_im[k*DW +: DW];
                xr <= vec_re[col];
                xi <= vec_im[col];
            end
        end

        mat_spmv_cmac_cmul #(.DW(DW)) u_cmul (
            .clk     (clk),
            .en      (en),
            .lane_en (s1_lane_en[k]),
            .v_re    (vr),
            .v_im    (vi),
            .x_re    (xr),
            .x_im    (xi),
            .p_re    (s2_pr[k]),
            .p_im    (s2_pi[k])
        );
    end

    // Beat valids and row markers travel alongside the lane data; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (en) begin
            s1_vld     <= accept;
            s1_last    <= s_last;
            s1_lane_en <= s_lane_en;
            s2_vld     <= s1_vld;
            s2_last    <= s1_last;
        end
    end

    // Lane reduction and accumulate; the first beat of a row starts from zero, wrapping is intended.
    always_comb begin
        sum_re = '0;
        sum_im = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_re = sum_re + ACC_W'(s2_pr[k]);
            sum_im = sum_im + ACC_W'(s2_pi[k]);
        end
        nxt_re = (first ? '0 : acc_re) + sum_re;
        nxt_im = (first ? '0 : acc_im) + sum_im;
    end

    // Accumulator, row counter and output register; a new row may replace a result in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_re  <= '0;
            acc_im  <= '0;
            first   <= 1'b1;
            row_cnt <= '0;
            m_vld   <= 1'b0;
            m_re    <= '0;
            m_im    <= '0;
            m_row   <= '0;
        end else if (en) begin
            m_vld <= s2_vld && s2_last;
            if (s2_vld) begin
                acc_re <= nxt_re;
                acc_im <= nxt_im;
                first  <= s2_last;
                if (s2_last) begin
                    m_re    <= nxt_re;
                    m_im    <= nxt_im;
                    m_row   <= row_cnt;
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_spmv_cmac.sv
module tb_mat_spmv_cmac;
    import mat_spmv_cmac_pkg::*;

    localparam int MAT_RANK = 16;
    localparam int LANES    = 4;
    localparam int DW       = 16;
    localparam int ACC_W    = 34;
    localparam int IDX_W    = idx_w(MAT_RANK);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   vec_wr_en;
    logic [IDX_W-1:0]       vec_wr_addr;
    logic [DW-1:0]          vec_wr_re, vec_wr_im;
    logic [LANES*IDX_W-1:0] s_col_index;
    logic [LANES*DW-1:0]    s_val_re, s_val_im;
    logic [LANES-1:0]       s_lane_en;
    logic                   s_last, s_vld, s_rdy;
    logic [ACC_W-1:0]       m_re, m_im;
    logic [IDX_W-1:0]       m_row;
    logic                   m_vld, m_rdy;

    always #5 clk = ~clk;

    mat_spmv_cmac #(.MAT_RANK(MAT_RANK), .LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_re(vec_wr_re), .vec_wr_im(vec_wr_im),
        .s_col_index(s_col_index), .s_val_re(s_val_re), .s_val_im(s_val_im), .s_lane_en(s_lane_en),
        .s_last(s_last), .s_vld(s_vld), .s_rdy(s_rdy),
        .m_re(m_re), .m_im(m_im), .m_row(m_row), .m_vld(m_vld), .m_rdy(m_rdy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: vector contents, current beat, running row sums, expected/observed results.
    int     xr_m [MAT_RANK];
    int     xi_m [MAT_RANK];
    int     b_col [LANES];
    int     b_re [LANES];
    int     b_im [LANES];
    bit     b_en [LANES];
    longint acc_re_m, acc_im_m;
    int     row_m;
    logic [ACC_W-1:0] exp_re[$], exp_im[$], got_re[$], got_im[$];
    int               exp_row[$], got_row[$];
    bit               rdy_rand = 1'b0;

    // Observe every accepted result (handshake completes at the following rising edge).
    always @(negedge clk) begin
        if (rst_n && m_vld && m_rdy) begin
            got_re.push_back(m_re);
            got_im.push_back(m_im);
            got_row.push_back(int'(m_row));
        end
    end

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            m_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_val();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic vec_write(input int a, input int re, input int im);
        vec_wr_en   = 1'b1;
        vec_wr_addr = a[IDX_W-1:0];
        vec_wr_re   = re[DW-1:0];
        vec_wr_im   = im[DW-1:0];
        tick();
        vec_wr_en   = 1'b0;
        xr_m[a]     = re;
        xi_m[a]     = im;
    endtask

    task automatic rand_beat();
        for (int k = 0; k < LANES; k++) begin
            b_col[k] = int'($urandom_range(0, MAT_RANK - 1));
            b_re[k]  = rand_val();
            b_im[k]  = rand_val();
            b_en[k]  = 1'($urandom_range(0, 1));
        end
    endtask

    // Present the current beat until accepted, then fold it into the model as complex arithmetic.
    task automatic send_beat(input bit last);
        int n = 0;
        for (int k = 0; k < LANES; k++) begin
            s_col_index[k*IDX_W +: IDX_W] = b_col[k][IDX_W-1:0];
            s_val_re[k*DW +: DW]          = b_re[k][DW-1:0];
            s_val_im[k*DW +: DW]          = b_im[k][DW-1:0];
            s_lane_en[k]                  = b_en[k];
        end
        s_last = last;
        s_vld  = 1'b1;
        @(negedge clk);
        while (!s_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        if (n >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_accept: s_rdy stayed %0b for %0d cycles, required 1", s_rdy, n);
            return;
        end
        for (int k = 0; k < LANES; k++) begin
            if (b_en[k]) begin
                acc_re_m += longint'(b_re[k]) * xr_m[b_col[k]] - longint'(b_im[k]) * xi_m[b_col[k]];
                acc_im_m += longint'(b_re[k]) * xi_m[b_col[k]] + longint'(b_im[k]) * xr_m[b_col[k]];
            end
        end
        if (last) begin
            exp_re.push_back(ACC_W'(acc_re_m));
            exp_im.push_back(ACC_W'(acc_im_m));
            exp_row.push_back(row_m);
            row_m    = (row_m + 1) % MAT_RANK;
            acc_re_m = 0;
            acc_im_m = 0;
        end
    endtask

    task automatic wait_rows(input int n);
        int c = 0;
        while (got_row.size() < n && c < 3000) begin
            tick();
            c++;
        end
        if (got_row.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL row_wait: got %0d results, required %0d", got_row.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_re = '0; vec_wr_im = '0;
        s_col_index = '0; s_val_re = '0; s_val_im = '0; s_lane_en = '0; s_last = 1'b0; s_vld = 1'b0;
        m_rdy = 1'b1;
        acc_re_m = 0; acc_im_m = 0; row_m = 0;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL reset_m_vld: got %0b, required 0", m_vld); end
        n_cmp++; if (m_re !== '0 || m_im !== '0) begin n_err++; $display("FAIL reset_data: got %0h/%0h, required 0/0", m_re, m_im); end
        n_cmp++; if (m_row !== '0) begin n_err++; $display("FAIL reset_m_row: got %0d, required 0", m_row); end
        n_cmp++; if (s_rdy !== 1'b0) begin n_err++; $display("FAIL reset_s_rdy: got %0b, required 0", s_rdy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat = 0;
        vec_write(3, 2, 1);
        rand_beat();
        b_col[0] = 3; b_re[0] = 3; b_im[0] = 4; b_en[0] = 1'b1;
        for (int k = 1; k < LANES; k++) b_en[k] = 1'b0;
        send_beat(1'b1);
        // Two further edges after the accepting edge: result is up in the third cycle of the beat.
        while (!m_vld && lat < 10) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL single_latency: got %0d edges, required 2", lat); end
        n_cmp++; if (m_re !== 34'd2 || m_im !== 34'd11) begin n_err++; $display("FAIL single_value: got (%0d,%0d), required (2,11)", $signed(m_re), $signed(m_im)); end
        wait_rows(exp_row.size());
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL single_row: got (%0d,%0d) row %0d, required (%0d,%0d) row %0d", $signed(gr), $signed(gi), gw, $signed(er), $signed(ei), ew); end
        end
    endtask

    task automatic test_two_beat();
        for (int k = 0; k < 8; k++) vec_write(k, k, 0);
        for (int k = 0; k < LANES; k++) begin b_col[k] = k; b_re[k] = 1; b_im[k] = 0; b_en[k] = 1'b1; end
        send_beat(1'b0);
        for (int k = 0; k < LANES; k++) begin b_col[k] = k + 4; b_re[k] = 0; b_im[k] = 1; end
        send_beat(1'b1);
        wait_rows(exp_row.size());
        if (got_re.size() > 0) begin
            n_cmp++;
            if (got_re[0] !== 34'd6 || got_im[0] !== 34'd22) begin n_err++; $display("FAIL two_beat_value: got (%0d,%0d), required (6,22)", $signed(got_re[0]), $signed(got_im[0])); end
        end
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL two_beat_row: got (%0d,%0d) row %0d, required (%0d,%0d) row %0d", $signed(gr), $signed(gi), gw, $signed(er), $signed(ei), ew); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < MAT_RANK; k++) vec_write(k, rand_val(), rand_val());
        fork
            begin
                for (int r = 0; r < 5; r++) begin
                    rand_beat();
                    send_beat(1'b1);
                end
            end
            begin
                int c = 0;
                logic [ACC_W-1:0] hr, hi; logic [IDX_W-1:0] hw;
                while (!m_vld && c < 50) begin tick(); c++; end
                m_rdy = 1'b0;
                hr = m_re; hi = m_im; hw = m_row;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    n_cmp++;
                    if (s_rdy !== 1'b0 || m_vld !== 1'b1 || m_re !== hr || m_im !== hi || m_row !== hw) begin
                        n_err++;
                        $display("FAIL stall_hold: cycle %0d s_rdy=%0b m_vld=%0b data (%0d,%0d,%0d), required 0/1 (%0d,%0d,%0d)", i, s_rdy, m_vld, $signed(m_re), $signed(m_im), m_row, $signed(hr), $signed(hi), hw);
                    end
                end
                m_rdy = 1'b1;
            end
        join
        wait_rows(exp_row.size());
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL stall_row: got (%0d,%0d) row %0d, required (%0d,%0d) row %0d", $signed(gr), $signed(gi), gw, $signed(er), $signed(ei), ew); end
        end
        repeat (6) tick();
        n_cmp++;
        if (got_row.size() !== 0) begin n_err++; $display("FAIL stall_extra: got %0d surplus results, required 0", got_row.size()); end
    endtask

    task automatic test_row_wrap();
        for (int r = 0; r < MAT_RANK + 2; r++) begin
            rand_beat();
            for (int k = 0; k < LANES; k++) b_en[k] = 1'b0;
            send_beat(1'b1);
        end
        wait_rows(exp_row.size());
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL wrap_row: got (%0d,%0d) row %0d, required (%0d,%0d) row %0d", $signed(gr), $signed(gi), gw, $signed(er), $signed(ei), ew); end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < LANES; k++) vec_write(k, -32768, -32768);
        for (int k = 0; k < LANES; k++) begin b_col[k] = k; b_re[k] = -32768; b_im[k] = -32768; b_en[k] = 1'b1; end
        for (int b = 0; b < 1024; b++) send_beat(b == 1023);
        for (int b = 0; b < 3; b++) send_beat(b == 2);
        wait_rows(exp_row.size());
        if (got_im.size() > 1) begin
            n_cmp++;
            if (got_im[1] !== 34'h2_0000_0000 || got_re[1] !== '0) begin n_err++; $display("FAIL overflow_wrap: got (%0h,%0h), required (0,200000000)", got_re[1], got_im[1]); end
        end
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL overflow_row: got (%0h,%0h) row %0d, required (%0h,%0h) row %0d", gr, gi, gw, er, ei, ew); end
        end
    endtask

    task automatic test_reset_mid_row();
        rand_beat(); send_beat(1'b0);
        rand_beat(); send_beat(1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (m_vld !== 1'b0 || s_rdy !== 1'b0) begin n_err++; $display("FAIL midrow_reset: m_vld=%0b s_rdy=%0b, required 0/0", m_vld, s_rdy); end
        rst_n    = 1'b1;
        acc_re_m = 0; acc_im_m = 0; row_m = 0;
        rand_beat(); b_en[0] = 1'b1; send_beat(1'b0);
        rand_beat(); send_beat(1'b1);
        wait_rows(exp_row.size());
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL midrow_row: got (%0d,%0d) row %0d, required (%0d,%0d) row %0d", $signed(gr), $signed(gi), gw, $signed(er), $signed(ei), ew); end
        end
    endtask

    task automatic test_random();
        rdy_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            int nb = int'($urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) vec_write(int'($urandom_range(0, MAT_RANK - 1)), rand_val(), rand_val());
            for (int b = 0; b < nb; b++) begin
                rand_beat();
                send_beat(b == nb - 1);
            end
        end
        rdy_rand = 1'b0;
        tick();
        tick();
        m_rdy = 1'b1;
        wait_rows(exp_row.size());
        while (exp_row.size() > 0 && got_row.size() > 0) begin
            logic [ACC_W-1:0] er, ei, gr, gi; int ew, gw;
            er = exp_re.pop_front(); ei = exp_im.pop_front(); ew = exp_row.pop_front();
            gr = got_re.pop_front(); gi = got_im.pop_front(); gw = got_row.pop_front();
            n_cmp++;
            if (gr !== er || gi !== ei || gw !== ew) begin n_err++; $display("FAIL random_row: got (%0d,%0d) row %0d, required (%0d,%0d) row %0d", $signed(gr), $signed(gi), gw, $signed(er), $signed(ei), ew); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_beat();
        test_stall();
        test_row_wrap();
        test_overflow();
        test_reset_mid_row();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
